mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC pipeline. Sits between the EX/MEM register and write-back.
- Owns the 4K x 16 data memory and the 12-bit stack pointer.
- Executes loads, stores, PUSH and POP in a single accept cycle.
- Executes the multi-cycle stack sequences for CALL, RET, RTI and interrupt entry, holding `stall` high so upstream freezes. Produces the registered MEM/WB outputs plus PC and CCR reload pulses.

Parameters:
- ADDR_W, 12, data memory address width; also the SP width.
- DATA_W, 16, data word width.
- SP_INIT, 2**ADDR_W-1, stack pointer value at reset (12'hFFF).
- INT_VEC_ADDR, 2, interrupt vector location: high word at this address, low word at this address +1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds an instruction; sampled only in IDLE.
- mem_rd  in  1  load (LDD).
- mem_wr  in  1  store (STD).
- push  in  1  PUSH.
- pop  in  1  POP.
- call  in  1  CALL.
- ret  in  1  RET.
- rti  in  1  RTI.
- reg_write  in  1  destination register write enable.
- mem_to_reg  in  1  write-back data source: 1 = memory, 0 = alu_out.
- rd_addr  in  3  destination register.
- alu_out  in  DATA_W  ALU result.
- addr  in  ADDR_W  effective address for LDD/STD.
- wdata  in  DATA_W  store / push data.
- pc  in  32  return address for CALL.
- ccr  in  3  current flags (saved on interrupt).
- int_req  in  1  interrupt request (level).
- int_pc  in  32  PC to save on interrupt.
- stall  out  1  high in every non-IDLE state.
- wb_valid  out  1  MEM/WB slot valid.
- wb_reg_write  out  1  register write enable to WB.
- wb_rd_addr  out  3  destination register to WB.
- wb_data  out  DATA_W  write-back data.
- pc_load  out  1  one-cycle pulse: load `pc_out` into the fetch PC.
- pc_out  out  32  PC reload value.
- ccr_load  out  1  one-cycle pulse: restore CCR.
- ccr_out  out  3  CCR restore value.
- sp_out  out  ADDR_W  current SP, for debug.

Behaviour:
- **Reset** (async, rst=1): state IDLE, SP=SP_INIT, int_pending=0. All outputs 0 except `sp_out`. Memory contents are not cleared. Reset mid-sequence aborts the sequence with no pc_load or ccr_load.
- **Memory:** combinational read, write on the clk rising edge.
- **SP arithmetic:** modulo 2**ADDR_W; wrap is silent, no error.
- **Push** writes mem[SP] then SP−1. **Pop** reads mem[SP+1] and sets SP+1.
- **Op priority** when more than one is asserted: call > ret > rti > push > pop > mem_rd > mem_wr.
- **int_pending:** set when int_req=1; cleared when the interrupt sequence is accepted.
- **IDLE decisions:**
  - If int_pending and in_valid=0: interrupt accept.
  - Else if in_valid: accept the op.
  - int_pending with in_valid=1 waits; upstream is responsible for injecting the bubble.
- **Single-cycle ops** (LDD, STD, PUSH, POP, ALU pass-through): MEM/WB registers update on the accept edge; latency 1.
  - wb_data = mem_to_reg ? read data : alu_out.
  - LDD read data = mem[addr]; POP read data = mem[SP+1].
  - STD and PUSH force wb_reg_write=0.
- **in_valid=0 in IDLE** with no interrupt: wb_valid=0, wb_reg_write=0.
- **CALL:**
  - Accept: mem[SP]=pc[31:16], SP−1, latch pc[15:0] → state CALL_LO.
  - CALL_LO: mem[SP]=lo, SP−1 → IDLE.
  - No write-back.
- **RET:**
  - Accept: lo=mem[SP+1], SP+1 → RET_HI.
  - RET_HI: pc_out={mem[SP+1], lo}, SP+1, pc_load=1 on the following cycle → IDLE.
- **Interrupt entry:**
  - Accept: latch int_pc and ccr; mem[SP]=int_pc[31:16], SP−1 → INT_LO.
  - INT_LO: mem[SP]=int_pc[15:0], SP−1 → INT_CCR.
  - INT_CCR: mem[SP]={13'b0, ccr}, SP−1; pc_out={mem[INT_VEC_ADDR], mem[INT_VEC_ADDR+1]}; pc_load next cycle → IDLE.
- **RTI:**
  - Accept: ccr_out=mem[SP+1][2:0], SP+1 → RTI_LO.
  - RTI_LO: lo=mem[SP+1], SP+1 → RTI_HI.
  - RTI_HI: pc_out={mem[SP+1], lo}, SP+1; pc_load=1 and ccr_load=1 together on the next cycle → IDLE.
- **Stall and upstream hold:** stall = (state != IDLE).
  - Upstream advances on the accept edge, then holds the next EX/MEM contents stable while stall=1.
  - Inputs are ignored during stall; the held instruction is accepted on the first IDLE cycle.
- **During multi-cycle sequences:** wb_valid=0 and wb_reg_write=0.
- **Pulse timing:** pc_load and ccr_load are registered and high exactly one cycle. pc_out and ccr_out hold their values until the next load.

Test Plan:
1. **Reset:** rst pulse → stall=0, wb_valid=0, pc_load=0, sp_out=12'hFFF.
2. **Store then load:** STD addr=0x010 wdata=0xBEEF, then LDD addr=0x010 rd=3 mem_to_reg=1 → one cycle after LDD accept: wb_data=0xBEEF, wb_rd_addr=3, wb_reg_write=1.
3. **Push/pop ordering:** PUSH 0x1234, PUSH 0x5678, POP rd=1, POP rd=2 → wb_data 0x5678 then 0x1234; SP goes FFE, FFD, FFE, FFF.
4. **CALL/RET round trip:**
   - CALL pc=0x000100A0 → stall high 1 cycle; mem[FFF]=0x0001, mem[FFE]=0x00A0, SP=FFD.
   - Then RET → stall 1 cycle; pc_load pulse with pc_out=0x000100A0; SP=FFF.
5. **Interrupt entry and RTI:**
   - Setup: mem[2]=0x0000, mem[3]=0x0200. Drive int_req=1, in_valid=0, int_pc=0x00000042, ccr=3'b101.
   - Required response: stall high 2 cycles; pc_load with pc_out=0x00000200; SP=FFC.
   - Then RTI → ccr_load with ccr_out=3'b101 and pc_load with pc_out=0x00000042 in the same cycle; SP=FFF.
6. **Reset mid-sequence:** rst asserted during CALL_LO → immediately state IDLE, stall=0, SP=FFF; no pc_load afterwards.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RISC pipeline (EX/MEM -> MEM/WB).
//
// Owns the data memory (2**ADDR_W x DATA_W, combinational read, write on the
// rising clock edge) and the stack pointer.
//
// Single-cycle operations (load, store, push, pop, ALU pass-through) update
// the MEM/WB registers on the accept edge.
//
// CALL, RET, RTI and interrupt entry run as multi-cycle stack sequences.
// While a sequence runs, stall is held high so that upstream freezes.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   in_valid            EX/MEM slot holds an instruction (sampled in IDLE only)
//   mem_rd/mem_wr       load / store
//   push/pop            stack push / pop
//   call/ret/rti        subroutine call, return, return-from-interrupt
//   reg_write,
//   mem_to_reg,
//   rd_addr             write-back control for the instruction
//   alu_out, addr,
//   wdata               ALU result, effective address, store/push data
//   pc                  return address pushed by CALL
//   ccr                 flags saved on interrupt entry
//   int_req, int_pc     level interrupt request and the PC to save
//   stall               high in every non-IDLE state
//   wb_*                registered MEM/WB outputs
//   pc_load/pc_out      one-cycle PC reload pulse and its value
//   ccr_load/ccr_out    one-cycle CCR restore pulse and its value
//   sp_out              current stack pointer
//
// Note: the 32-bit PC is stored as two words, so DATA_W is expected to be 16.
module mem_stage #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] SP_INIT      = '1,
  parameter int                INT_VEC_ADDR = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              push,
  input  logic              pop,
  input  logic              call,
  input  logic              ret,
  input  logic              rti,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [2:0]        rd_addr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [31:0]       pc,
  input  logic [2:0]        ccr,
  input  logic              int_req,
  input  logic [31:0]       int_pc,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [2:0]        wb_rd_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_load,
  output logic [31:0]       pc_out,
  output logic              ccr_load,
  output logic [2:0]        ccr_out,
  output logic [ADDR_W-1:0] sp_out
);

  localparam logic [ADDR_W-1:0] VEC_HI = ADDR_W'(INT_VEC_ADDR);
  localparam logic [ADDR_W-1:0] VEC_LO = ADDR_W'(INT_VEC_ADDR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_LO,
    S_RET_HI,
    S_INT_LO,
    S_INT_CCR,
    S_RTI_LO,
    S_RTI_HI
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic              r_int_pending;
  logic [DATA_W-1:0] r_lo;        // low PC word carried between sequence steps
  logic [DATA_W-1:0] r_int_lo;    // low half of the interrupted PC
  logic [2:0]        r_int_ccr;   // flags captured at interrupt accept
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] w_sp_inc;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [DATA_W-1:0] w_top;       // mem[SP+1], the current top of stack
  logic [DATA_W-1:0] w_rdata;
  logic              w_idle;
  logic              w_int_accept;
  logic              w_op_accept;
  logic              w_sel_call, w_sel_ret, w_sel_rti, w_sel_push;
  logic              w_sel_pop, w_sel_ld, w_sel_st;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_sp_inc     = r_sp + ADDR_W'(1);
  assign w_sp_dec     = r_sp - ADDR_W'(1);
  assign w_top        = r_mem[w_sp_inc];
  assign w_idle       = (r_state == S_IDLE);
  // A pending interrupt only wins an empty slot; a valid instruction goes first.
  assign w_int_accept = w_idle && r_int_pending && !in_valid;
  assign w_op_accept  = w_idle && in_valid;

  assign stall  = !w_idle;
  assign sp_out = r_sp;

  // Fixed priority: call > ret > rti > push > pop > mem_rd > mem_wr.
  always_comb begin
    w_sel_call = call;
    w_sel_ret  = !call && ret;
    w_sel_rti  = !call && !ret && rti;
    w_sel_push = !(call || ret || rti) && push;
    w_sel_pop  = !(call || ret || rti || push) && pop;
    w_sel_ld   = !(call || ret || rti || push || pop) && mem_rd;
    w_sel_st   = !(call || ret || rti || push || pop || mem_rd) && mem_wr;
  end

  assign w_rdata = w_sel_pop ? w_top : r_mem[addr];

  // Single memory write port, shared by stores and all stack pushes.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sp;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_int_accept) begin
          w_we    = 1'b1;
          w_wdata = int_pc[31:16];
        end else if (w_op_accept) begin
          if (w_sel_call) begin
            w_we    = 1'b1;
            w_wdata = pc[31:16];
          end else if (w_sel_push) begin
            w_we    = 1'b1;
            w_wdata = wdata;
          end else if (w_sel_st) begin
            w_we    = 1'b1;
            w_waddr = addr;
            w_wdata = wdata;
          end
        end
      end
      S_CALL_LO: begin
        w_we    = 1'b1;
        w_wdata = r_lo;
      end
      S_INT_LO: begin
        w_we    = 1'b1;
        w_wdata = r_int_lo;
      end
      S_INT_CCR: begin
        w_we    = 1'b1;
        w_wdata = {{(DATA_W-3){1'b0}}, r_int_ccr};
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Sequence scratch data; only consumed after being written, so no reset.
  always_ff @(posedge clk) begin
    if (w_int_accept) begin
      r_int_lo  <= int_pc[15:0];
      r_int_ccr <= ccr;
    end
    if (w_op_accept && w_sel_call) begin
      r_lo <= pc[15:0];
    end else if ((w_op_accept && w_sel_ret) || (r_state == S_RTI_LO)) begin
      r_lo <= w_top;
    end
  end

  // ---- EX/MEM -> MEM/WB stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sp          <= SP_INIT;
      r_int_pending <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd_addr    <= '0;
      wb_data       <= '0;
      pc_load       <= 1'b0;
      pc_out        <= '0;
      ccr_load      <= 1'b0;
      ccr_out       <= '0;
    end else begin
      pc_load      <= 1'b0;
      ccr_load     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;

      if (w_int_accept) begin
        r_int_pending <= 1'b0;
      end else if (int_req) begin
        r_int_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_int_accept) begin
            r_sp    <= w_sp_dec;
            r_state <= S_INT_LO;
          end else if (w_op_accept) begin
            if (w_sel_call) begin
              r_sp    <= w_sp_dec;
              r_state <= S_CALL_LO;
            end else if (w_sel_ret) begin
              r_sp    <= w_sp_inc;
              r_state <= S_RET_HI;
            end else if (w_sel_rti) begin
              r_sp    <= w_sp_inc;
              ccr_out <= w_top[2:0];
              r_state <= S_RTI_LO;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write && !w_sel_push && !w_sel_st;
              wb_rd_addr   <= rd_addr;
              wb_data      <= mem_to_reg ? w_rdata : alu_out;
              if (w_sel_push) begin
                r_sp <= w_sp_dec;
              end else if (w_sel_pop) begin
                r_sp <= w_sp_inc;
              end
            end
          end
        end
        S_CALL_LO: begin
          r_sp    <= w_sp_dec;
          r_state <= S_IDLE;
        end
        S_RET_HI: begin
          r_sp    <= w_sp_inc;
          pc_out  <= {w_top, r_lo};
          pc_load <= 1'b1;
          r_state <= S_IDLE;
        end
        S_INT_LO: begin
          r_sp    <= w_sp_dec;
          r_state <= S_INT_CCR;
        end
        S_INT_CCR: begin
          r_sp    <= w_sp_dec;
          pc_out  <= {r_mem[VEC_HI], r_mem[VEC_LO]};
          pc_load <= 1'b1;
          r_state <= S_IDLE;
        end
        S_RTI_LO: begin
          r_sp    <= w_sp_inc;
          r_state <= S_RTI_HI;
        end
        S_RTI_HI: begin
          r_sp     <= w_sp_inc;
          pc_out   <= {w_top, r_lo};
          pc_load  <= 1'b1;
          ccr_load <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
